// File: rtl/coef_ram_loader.sv
// Writable coefficient table for the distributed-arithmetic FIR: serial load
// through a valid/ready handshake, registered 1-cycle read port, load status and checksum.
module coef_ram_loader #(
    parameter  int WIDTH_COEF0 = 8,
    parameter  int N_TAPS      = 16,
    localparam int DEPTH       = N_TAPS / 2,
    localparam int ADDR_W      = $clog2(N_TAPS / 2)
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   in_valid,
    input  logic [WIDTH_COEF0-1:0] in_data,
    output logic                   in_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   loaded,
    output logic [WIDTH_COEF0-1:0] chk,
    input  logic [ADDR_W-1:0]      add,
    output logic [WIDTH_COEF0-1:0] q,
    output logic [1:0]             dbg_state
);

    // Handshake: a word transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on registered state, never on in_valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_q;
    logic [ADDR_W-1:0]      wr_ptr_q;
    logic [WIDTH_COEF0-1:0] chk_q;
    logic                   loaded_q;
    logic [WIDTH_COEF0-1:0] q_q;
    logic [WIDTH_COEF0-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            chk_q    <= '0;
            loaded_q <= 1'b0;
            q_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // Read samples the pre-write contents, giving read-before-write.
            q_q <= mem_q[add];
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= LOAD;
                        wr_ptr_q <= '0;
                        chk_q    <= '0;
                        loaded_q <= 1'b0;
                    end
                end
                LOAD: begin
                    // abort wins over a word presented in the same cycle
                    if (abort) begin
                        state_q  <= IDLE;
                        loaded_q <= 1'b0;
                    end else if (in_valid) begin
                        mem_q[wr_ptr_q] <= in_data;
                        chk_q           <= chk_q + in_data;
                        if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                            state_q <= DONE;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    loaded_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q == LOAD);
    assign done      = (state_q == DONE);
    assign loaded    = loaded_q;
    assign chk       = chk_q;
    assign q         = q_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_coef_ram_loader.sv
// Directed bench for coef_ram_loader: reset, full/stalled loads, abort,
// checksum wrap and read-before-write, checked against hand-computed tables.
module tb_coef_ram_loader;

    localparam logic [1:0] ST_IDLE = 2'd0;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic       loaded;
    logic [7:0] chk;
    logic [2:0] add = 3'd0;
    logic [7:0] q;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;

    logic [7:0] wr_words [8];
    logic [7:0] exp_tab  [8];

    coef_ram_loader #(.WIDTH_COEF0(8), .N_TAPS(16)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .loaded    (loaded),
        .chk       (chk),
        .add       (add),
        .q         (q),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            add = 3'(i);
            @(negedge clk);
            check($sformatf("%s_rd%0d", tag, i), q, exp_tab[i]);
        end
    endtask

    // Loads wr_words with `stall` idle cycles between words.
    task automatic load_table(input string tag, input int stall, input logic [7:0] exp_chk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_ready"}, in_ready, 1);
        check({tag, "_chk0"}, chk, 0);
        check({tag, "_loaded0"}, loaded, 0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                for (int s = 0; s < stall; s++) begin
                    in_valid = 1'b0;
                    in_data  = 8'hEE;
                    @(negedge clk);
                    check($sformatf("%s_stall%0d_%0d", tag, i, s), {done, busy}, 2'b01);
                end
            end
            in_valid   = 1'b1;
            in_data    = wr_words[i];
            exp_tab[i] = wr_words[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_ready_done"}, in_ready, 0);
        check({tag, "_chk"}, chk, exp_chk);
        check({tag, "_loaded_in_done"}, loaded, 0);
        @(negedge clk);
        check({tag, "_done_off"}, done, 0);
        check({tag, "_loaded"}, loaded, 1);
        check({tag, "_idle"}, dbg_state, ST_IDLE);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) exp_tab[i] = 8'h00;

        // power-on reset
        #12;
        check("por_q", q, 0);
        check("por_chk", chk, 0);
        check("por_ready", in_ready, 0);
        check("por_busy", busy, 0);
        check("por_done", done, 0);
        check("por_loaded", loaded, 0);
        @(negedge clk);
        clr = 1'b1;
        read_all("por");

        // full back-to-back load 8..1
        for (int i = 0; i < 8; i++) wr_words[i] = 8'(8 - i);
        load_table("full", 0, 8'h24);
        read_all("full");

        // reset in the middle of a load
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h33;
        repeat (3) @(negedge clk);
        #2 clr = 1'b0;
        #1;
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_chk", chk, 0);
        check("rst_loaded", loaded, 0);
        check("rst_q", q, 0);
        check("rst_state", dbg_state, ST_IDLE);
        in_valid = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        for (int i = 0; i < 8; i++) exp_tab[i] = 8'h00;
        read_all("rst");

        // abort coincident with a 4th word
        load_table("pre_abort", 0, 8'h24);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid   = 1'b1;
            in_data    = 8'hFF;
            exp_tab[i] = 8'hFF;
            @(negedge clk);
        end
        in_data = 8'h11;
        abort   = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_state", dbg_state, ST_IDLE);
        check("abort_loaded", loaded, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_chk", chk, 8'hFD);
        read_all("abort");

        // stalled load: valid pattern 1,0,0,1,0,0,...
        for (int i = 0; i < 8; i++) wr_words[i] = 8'(8 - i);
        load_table("stall", 2, 8'h24);
        read_all("stall");

        // checksum wraps to zero
        for (int i = 0; i < 8; i++) wr_words[i] = 8'h80;
        load_table("wrap", 0, 8'h00);
        read_all("wrap");

        // read-before-write at add=2, plus a start pulse mid-load
        wr_words[0] = 8'h10; wr_words[1] = 8'h20; wr_words[2] = 8'h5A; wr_words[3] = 8'h30;
        wr_words[4] = 8'h40; wr_words[5] = 8'h50; wr_words[6] = 8'h60; wr_words[7] = 8'h70;
        @(negedge clk);
        add   = 3'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) check("rbw_old", q, 8'h80);
            if (i == 4) check("rbw_new", q, 8'h5A);
            in_valid   = 1'b1;
            in_data    = wr_words[i];
            start      = (i == 4);
            exp_tab[i] = wr_words[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("rbw_done", done, 1);
        check("rbw_chk", chk, 8'h1A);
        @(negedge clk);
        check("rbw_loaded", loaded, 1);
        read_all("rbw");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
